// File: rtl/hazard_stall_unit_pkg.sv
`default_nettype none
// ==================================================================
// Package : hazard_stall_unit_pkg
// Shared Tuse/Tnew encodings and MDU latency defaults.
// Rev     : 1.0
// ==================================================================
package hazard_stall_unit_pkg;

  // Tnew/Tuse code points; all-ones on a Tuse field means "operand not read"
  typedef enum logic [1:0] {
    T_NOW     = 2'd0,
    T_ALU     = 2'd1,
    T_LOAD    = 2'd2,
    TUSE_NONE = 2'd3
  } t_code_e;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

endpackage
`default_nettype wire

// File: rtl/hazard_stall_unit_mdu_busy_counter.sv
`default_nettype none
// ==================================================================
// Module : mdu_busy_counter
// Multi-cycle MDU occupancy counter; a new start reloads the count.
// Rev    : 1.0
// ==================================================================
module mdu_busy_counter
  import hazard_stall_unit_pkg::*;
#(
  parameter int BUSY_W   = 4,
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic div,
  output logic busy
);

  localparam logic [BUSY_W-1:0] MULT_LD = BUSY_W'(MULT_CYC);
  localparam logic [BUSY_W-1:0] DIV_LD  = BUSY_W'(DIV_CYC);

  logic [BUSY_W-1:0] busy_cnt_d;
  logic [BUSY_W-1:0] busy_cnt_q;

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (start) begin
      busy_cnt_d = div ? DIV_LD : MULT_LD;
    end else if (busy_cnt_q != '0) begin
      busy_cnt_d = busy_cnt_q - BUSY_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_cnt_q <= '0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // The instruction sitting in E already occupies the MDU before the load lands
  assign busy = (busy_cnt_q != '0) || start;

endmodule
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ==================================================================
// Module : hazard_stall_unit
// D-stage stall/flush control from Tuse/Tnew with E/M shadow tracking.
// Rev    : 1.0
// ==================================================================
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int T_W         = 2,
  parameter int MULT_CYC    = MULT_CYC_DEF,
  parameter int DIV_CYC     = DIV_CYC_DEF,
  parameter int BUSY_W      = 4,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [REG_AW-1:0]      d_rs,
  input  logic [REG_AW-1:0]      d_rt,
  input  logic [T_W-1:0]         d_tuse_rs,
  input  logic [T_W-1:0]         d_tuse_rt,
  input  logic [REG_AW-1:0]      d_a3,
  input  logic [T_W-1:0]         d_tnew,
  input  logic                   d_md_use,
  input  logic                   d_md_start,
  input  logic                   d_md_div,
  input  logic                   flush,
  output logic                   en_pc,
  output logic                   en_d,
  output logic                   clr_e,
  output logic                   stall_reg,
  output logic                   stall_md,
  output logic                   md_busy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam logic [T_W-1:0] TUSE_ALL = {T_W{1'b1}};
  localparam logic [T_W-1:0] TNEW_NOW = T_W'(T_NOW);

  logic [REG_AW-1:0]      e_a3_d, e_a3_q, m_a3_d, m_a3_q;
  logic [T_W-1:0]         e_tnew_d, e_tnew_q, m_tnew_d, m_tnew_q;
  logic                   e_md_start_d, e_md_start_q;
  logic                   e_md_div_d, e_md_div_q;
  logic [STALL_CNT_W-1:0] stall_cycles_d, stall_cycles_q;

  logic hit_e_rs, hit_e_rt, hit_m_rs, hit_m_rt;
  logic stall;

  assign hit_e_rs = (d_rs == e_a3_q) && (e_a3_q != '0) && (d_tuse_rs != TUSE_ALL) && (d_tuse_rs < e_tnew_q);
  assign hit_e_rt = (d_rt == e_a3_q) && (e_a3_q != '0) && (d_tuse_rt != TUSE_ALL) && (d_tuse_rt < e_tnew_q);
  assign hit_m_rs = (d_rs == m_a3_q) && (m_a3_q != '0) && (d_tuse_rs != TUSE_ALL) && (d_tuse_rs < m_tnew_q);
  assign hit_m_rt = (d_rt == m_a3_q) && (m_a3_q != '0) && (d_tuse_rt != TUSE_ALL) && (d_tuse_rt < m_tnew_q);

  mdu_busy_counter #(
    .BUSY_W   (BUSY_W),
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_mdu_busy (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (e_md_start_q),
    .div     (e_md_div_q),
    .busy    (md_busy)
  );

  // Raw stall causes stay visible even when a flush overrides them
  assign stall_reg = hit_e_rs || hit_e_rt || hit_m_rs || hit_m_rt;
  assign stall_md  = d_md_use && md_busy;
  assign stall     = (stall_reg || stall_md) && !flush;
  assign en_pc     = !stall;
  assign en_d      = !stall;
  assign clr_e     = stall || flush;
  assign stall_cycles = stall_cycles_q;

  always_comb begin
    m_a3_d   = e_a3_q;
    m_tnew_d = (e_tnew_q == TNEW_NOW) ? TNEW_NOW : (e_tnew_q - T_W'(1));
    if (clr_e) begin
      e_a3_d       = '0;
      e_tnew_d     = '0;
      e_md_start_d = 1'b0;
      e_md_div_d   = 1'b0;
    end else begin
      e_a3_d       = d_a3;
      e_tnew_d     = d_tnew;
      e_md_start_d = d_md_start;
      e_md_div_d   = d_md_div;
    end
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_a3_q         <= '0;
      e_tnew_q       <= '0;
      e_md_start_q   <= 1'b0;
      e_md_div_q     <= 1'b0;
      m_a3_q         <= '0;
      m_tnew_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      e_a3_q         <= e_a3_d;
      e_tnew_q       <= e_tnew_d;
      e_md_start_q   <= e_md_start_d;
      e_md_div_q     <= e_md_div_d;
      m_a3_q         <= m_a3_d;
      m_tnew_q       <= m_tnew_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ==================================================================
// Module : tb_hazard_stall_unit
// Self-checking bench: directed test-plan sequences plus random traffic.
// Rev    : 1.0
// ==================================================================
module tb_hazard_stall_unit;

  localparam int     MULT_N = 5;
  localparam int     DIV_N  = 10;
  localparam longint CNT_MAX = 64'd4294967295;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_use, d_md_start, d_md_div, flush;
  logic       en_pc, en_d, clr_e, stall_reg, stall_md, md_busy;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference: list of in-flight writers with the cycle they entered E
  int     w_a3[$];
  int     w_tnew[$];
  int     w_cyc[$];
  int     cyc = 0;
  int     md_end = -1;
  longint m_cnt = 0;

  hazard_stall_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .d_rs         (d_rs),
    .d_rt         (d_rt),
    .d_tuse_rs    (d_tuse_rs),
    .d_tuse_rt    (d_tuse_rt),
    .d_a3         (d_a3),
    .d_tnew       (d_tnew),
    .d_md_use     (d_md_use),
    .d_md_start   (d_md_start),
    .d_md_div     (d_md_div),
    .flush        (flush),
    .en_pc        (en_pc),
    .en_d         (en_d),
    .clr_e        (clr_e),
    .stall_reg    (stall_reg),
    .stall_md     (stall_md),
    .md_busy      (md_busy),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // An operand read at Tuse is late if the writer still needs more cycles than that
  function automatic bit late(input int a3, input int remaining, input int addr, input int tuse);
    return (a3 != 0) && (a3 == addr) && (tuse != 3) && (tuse < remaining);
  endfunction

  function automatic void model_eval(output bit sreg, output bit smd, output bit busy,
                                     output bit stl, output bit clr);
    int age;
    sreg = 1'b0;
    foreach (w_cyc[i]) begin
      age = cyc - w_cyc[i];
      if (age >= 0 && age <= 1) begin
        if (late(w_a3[i], w_tnew[i] - age, int'(d_rs), int'(d_tuse_rs)) ||
            late(w_a3[i], w_tnew[i] - age, int'(d_rt), int'(d_tuse_rt)))
          sreg = 1'b1;
      end
    end
    busy = (md_end >= cyc);
    smd  = d_md_use && busy;
    stl  = (sreg || smd) && !flush;
    clr  = stl || flush;
  endfunction

  initial begin
    bit sreg, smd, busy, stl, clr;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        w_a3.delete();
        w_tnew.delete();
        w_cyc.delete();
        cyc = 0;
        md_end = -1;
        m_cnt = 0;
      end else begin
        model_eval(sreg, smd, busy, stl, clr);
        if (!clr) begin
          if (d_a3 != 0) begin
            w_a3.push_back(int'(d_a3));
            w_tnew.push_back(int'(d_tnew));
            w_cyc.push_back(cyc + 1);
          end
          if (d_md_start) md_end = cyc + 1 + (d_md_div ? DIV_N : MULT_N);
        end
        if (stl && m_cnt < CNT_MAX) m_cnt++;
        cyc++;
        while (w_cyc.size() > 0 && (cyc - w_cyc[0]) > 1) begin
          void'(w_a3.pop_front());
          void'(w_tnew.pop_front());
          void'(w_cyc.pop_front());
        end
      end
    end
  end

  initial begin
    bit sreg, smd, busy, stl, clr;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        model_eval(sreg, smd, busy, stl, clr);
        chk("en_pc", en_pc, !stl);
        chk("en_d", en_d, !stl);
        chk("clr_e", clr_e, clr);
        chk("stall_reg", stall_reg, sreg);
        chk("stall_md", stall_md, smd);
        chk("md_busy", md_busy, busy);
        chk("stall_cycles", stall_cycles, m_cnt);
      end
    end
  end

  task automatic drive(input int rs, input int rt, input int tur, input int tut, input int a3,
                       input int tnew, input int use_md, input int st, input int dv, input int fl);
    @(posedge clk);
    #1;
    d_rs = 5'(rs);  d_rt = 5'(rt);
    d_tuse_rs = 2'(tur);  d_tuse_rt = 2'(tut);
    d_a3 = 5'(a3);  d_tnew = 2'(tnew);
    d_md_use = use_md[0];  d_md_start = st[0];  d_md_div = dv[0];
    flush = fl[0];
  endtask

  task automatic nop();
    drive(0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic md_seq(input int is_div, input string name, input longint exp_n);
    int n;
    drive(0, 0, 3, 3, 0, 0, 1, 1, is_div, 0);
    #1 chk({name, "_idle_busy"}, md_busy, 0);
    drive(0, 0, 3, 3, 4, 1, 1, 0, 0, 0);
    #1 chk({name, "_busy_at_e"}, md_busy, 1);
    n = 0;
    while (en_pc == 1'b0 && n < 40) begin
      n++;
      @(posedge clk);
      #2;
    end
    chk({name, "_stall_len"}, n, exp_n);
  endtask

  initial begin
    reset_n = 1'b0;
    d_rs = '0; d_rt = '0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
    d_a3 = '0; d_tnew = '0; d_md_use = 1'b0; d_md_start = 1'b0; d_md_div = 1'b0; flush = 1'b0;
    #12;
    chk("rst_en_pc", en_pc, 1);
    chk("rst_clr_e", clr_e, 0);
    chk("rst_md_busy", md_busy, 0);
    chk("rst_cnt", stall_cycles, 0);
    reset_n = 1'b1;
    chk_en = 1'b1;
    nop();

    // lw $1 then beq $1: two bubbles
    drive(0, 0, 3, 3, 1, 2, 0, 0, 0, 0);
    #1 chk("lw_issue_en_pc", en_pc, 1);
    drive(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    #1 chk("beq_stall1_en_pc", en_pc, 0);
    chk("beq_stall1_clr_e", clr_e, 1);
    chk("beq_stall1_reg", stall_reg, 1);
    @(posedge clk); #2 chk("beq_stall2_en_pc", en_pc, 0);
    @(posedge clk); #2 chk("beq_go_en_pc", en_pc, 1);
    chk("beq_cnt", stall_cycles, 2);
    nop();

    // addu $2 then sw with $2 as store data: no stall
    drive(0, 0, 3, 3, 2, 1, 0, 0, 0, 0);
    drive(5, 2, 1, 2, 0, 0, 0, 0, 0, 0);
    #1 chk("sw_stall_reg", stall_reg, 0);
    chk("sw_en_pc", en_pc, 1);
    nop();

    // writes to $0 never create hazards
    drive(0, 0, 3, 3, 0, 2, 0, 0, 0, 0);
    drive(0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    #1 chk("r0_stall_reg", stall_reg, 0);
    chk("r0_en_pc", en_pc, 1);
    nop();

    // flush overrides an active load-use hazard
    drive(0, 0, 3, 3, 3, 2, 0, 0, 0, 0);
    drive(3, 0, 0, 3, 0, 0, 0, 0, 0, 1);
    #1 chk("fl_en_pc", en_pc, 1);
    chk("fl_en_d", en_d, 1);
    chk("fl_clr_e", clr_e, 1);
    chk("fl_stall_reg", stall_reg, 1);
    nop();
    #1 chk("fl_cnt", stall_cycles, 2);
    nop();

    md_seq(1, "div", 11);
    nop();
    #1 chk("div_cnt", stall_cycles, 13);
    md_seq(0, "mult", 6);
    nop();
    #1 chk("mult_cnt", stall_cycles, 19);
    nop();

    // async reset with the divider four cycles into its count
    drive(0, 0, 3, 3, 0, 0, 1, 1, 1, 0);
    drive(0, 0, 3, 3, 4, 1, 1, 0, 0, 0);
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk("ar_md_busy", md_busy, 0);
    chk("ar_stall_md", stall_md, 0);
    chk("ar_cnt", stall_cycles, 0);
    chk("ar_en_pc", en_pc, 1);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #2 chk("ar_post_en_pc", en_pc, 1);
    chk("ar_post_cnt", stall_cycles, 0);

    repeat (3000) begin
      int use_md;
      use_md = ($urandom_range(0, 9) < 3) ? 1 : 0;
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 2), use_md,
            (use_md != 0 && $urandom_range(0, 2) == 0) ? 1 : 0, $urandom_range(0, 1),
            ($urandom_range(0, 11) == 0) ? 1 : 0);
    end
    nop();
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
